arp_frame_tx: RTL and testbench

Parametrised ARP frame transmitter. It builds a complete Ethernet II ARP request or reply frame: preamble, SFD, header, ARP body, zero padding and a CRC-32 FCS computed on the fly. The frame is presented one byte per clk as a low/high nibble pair to the downstream DDR nibble serialiser. MAC/IP addresses and opcode are run-time inputs, and transmissions are started by a handshake followed by an enforced inter-frame gap.

---
 rtl/arp_frame_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_arp_frame_tx.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_frame_tx.sv
// arp_frame_tx: Ethernet II ARP request/reply frame transmitter.
// Emits preamble, SFD, 42-byte ARP header/body, zero pad and a CRC-32 FCS,
// one byte per clk as a low/high nibble pair (data_1 = [3:0], data_2 = [7:4]).
// Build option: define ARP_AUTO_REPEAT_EN to make an accepted start repeat the
// frame forever (gratuitous ARP beacon); only rst stops it.
//
// Handshake: start is a request, busy is its inverse-ready. A start sampled on
// a rising edge while busy=0 is accepted at that edge (fields latched, busy=1);
// any start seen while busy=1 is dropped, never queued.
module arp_frame_tx #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_reply,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic [47:0] tgt_mac,
    input  logic [31:0] tgt_ip,
    output logic        busy,
    output logic        done,
    output logic        tx_en,
    output logic [3:0]  data_1,
    output logic [3:0]  data_2,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_HDR  = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_IFG  = 3'd6
    } state_t;

    localparam int          PAD_BYTES = MIN_FRAME_BYTES - 42;
    localparam logic [10:0] PRE_LAST  = 11'(PREAMBLE_BYTES - 1);
    localparam logic [10:0] HDR_LAST  = 11'd41;
    localparam logic [10:0] PAD_LAST  = 11'(PAD_BYTES - 1);
    localparam logic [10:0] FCS_LAST  = 11'd3;
    localparam logic [10:0] IFG_LAST  = 11'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q;
    logic [31:0] crc_q;
    logic [31:0] crc_inv;
    logic        f_is_reply;
    logic [47:0] f_src_mac, f_tgt_mac;
    logic [31:0] f_src_ip, f_tgt_ip;
    logic [7:0]  hdr_b, fcs_b, byte_d, byte_q;
    logic        tx_en_d, tx_en_q, done_d, done_q;
    logic        accept, launch;
    logic        rpt_q;

    // Byte i (0 = first sent) of a MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
        logic [47:0] s;
        s = m << {i, 3'b000};
        return s[47:40];
    endfunction

    // Byte i (0 = first sent) of an IPv4 address.
    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] i);
        logic [31:0] s;
        s = a << {i, 3'b000};
        return s[31:24];
    endfunction

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Header byte at position idx: Ethernet header followed by the ARP body.
    function automatic logic [7:0] hdr_byte(
        input logic [10:0] idx,
        input logic        rep,
        input logic [47:0] smac,
        input logic [31:0] sip,
        input logic [47:0] tmac,
        input logic [31:0] tip
    );
        logic [7:0] b;
        b = 8'h00;
        if (idx < 11'd6)       b = rep ? mac_byte(tmac, 3'(idx)) : 8'hFF;
        else if (idx < 11'd12) b = mac_byte(smac, 3'(idx - 11'd6));
        else if (idx < 11'd22) begin
            case (idx)
                11'd12:  b = 8'h08;
                11'd13:  b = 8'h06;
                11'd14:  b = 8'h00;
                11'd15:  b = 8'h01;
                11'd16:  b = 8'h08;
                11'd17:  b = 8'h00;
                11'd18:  b = 8'h06;
                11'd19:  b = 8'h04;
                11'd20:  b = 8'h00;
                default: b = rep ? 8'h02 : 8'h01;
            endcase
        end
        else if (idx < 11'd28) b = mac_byte(smac, 3'(idx - 11'd22));
        else if (idx < 11'd32) b = ip_byte(sip, 2'(idx - 11'd28));
        else if (idx < 11'd38) b = rep ? mac_byte(tmac, 3'(idx - 11'd32)) : 8'h00;
        else                   b = ip_byte(tip, 2'(idx - 11'd38));
        return b;
    endfunction

    assign accept  = (state_q == S_IDLE) && start && !rpt_q;
    assign launch  = (state_q == S_IDLE) && (state_d == S_PRE);
    assign crc_inv = ~crc_q;
    assign hdr_b   = hdr_byte(cnt_q, f_is_reply, f_src_mac, f_src_ip, f_tgt_mac, f_tgt_ip);

`ifdef ARP_AUTO_REPEAT_EN
    // Arm repetition on the first accepted start; only reset disarms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rpt_q <= 1'b0;
        else if (accept) rpt_q <= 1'b1;
    end
`else
    assign rpt_q = 1'b0;
`endif

    // FCS byte select, least significant byte of the inverted CRC first.
    always_comb begin
        fcs_b = 8'h00;
        case (cnt_q[1:0])
            2'd0:    fcs_b = crc_inv[7:0];
            2'd1:    fcs_b = crc_inv[15:8];
            2'd2:    fcs_b = crc_inv[23:16];
            default: fcs_b = crc_inv[31:24];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state and the byte/strobe to be registered onto the outputs.
    always_comb begin
        state_d = state_q;
        byte_d  = 8'h00;
        tx_en_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start || rpt_q) state_d = S_PRE;
            S_PRE: begin
                tx_en_d = 1'b1;
                byte_d  = 8'h55;
                if (cnt_q == PRE_LAST) state_d = S_SFD;
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                byte_d  = 8'hD5;
                state_d = S_HDR;
            end
            S_HDR: begin
                tx_en_d = 1'b1;
                byte_d  = hdr_b;
                if (cnt_q == HDR_LAST) state_d = (PAD_BYTES > 0) ? S_PAD : S_FCS;
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                byte_d  = 8'h00;
                if (cnt_q == PAD_LAST) state_d = S_FCS;
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                byte_d  = fcs_b;
                if (cnt_q == FCS_LAST) state_d = S_IFG;
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared byte counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        cnt_q <= 11'd0;
        else if (state_d != state_q)     cnt_q <= 11'd0;
        else if (state_q != S_IDLE)      cnt_q <= cnt_q + 11'd1;
    end

    // Capture addresses and opcode at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_is_reply <= 1'b0;
            f_src_mac  <= 48'h0;
            f_src_ip   <= 32'h0;
            f_tgt_mac  <= 48'h0;
            f_tgt_ip   <= 32'h0;
        end else if (accept) begin
            f_is_reply <= is_reply;
            f_src_mac  <= src_mac;
            f_src_ip   <= src_ip;
            f_tgt_mac  <= tgt_mac;
            f_tgt_ip   <= tgt_ip;
        end
    end

    // Running CRC over header and pad bytes, reseeded at each frame launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   crc_q <= 32'hFFFFFFFF;
        else if (launch)            crc_q <= 32'hFFFFFFFF;
        else if (state_q == S_HDR)  crc_q <= crc_next(crc_q, hdr_b);
        else if (state_q == S_PAD)  crc_q <= crc_next(crc_q, 8'h00);
    end

    // Output registers: the line lags the state by one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q  <= 8'h00;
            tx_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            tx_en_q <= tx_en_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE) || rpt_q;
    assign done      = done_q;
    assign tx_en     = tx_en_q;
    assign data_1    = byte_q[3:0];
    assign data_2    = byte_q[7:4];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_arp_frame_tx.sv
// Directed bench for arp_frame_tx: default-parameter instance plus a
// minimum-size instance (1 preamble byte, no pad).
module tb_arp_frame_tx;

    logic        clk;
    logic        rst;
    logic        start, start2;
    logic        is_reply;
    logic [47:0] src_mac, tgt_mac;
    logic [31:0] src_ip, tgt_ip;
    logic        busy, done, tx_en;
    logic [3:0]  data_1, data_2;
    logic [2:0]  state_dbg;
    logic        busy2, done2, tx_en2;
    logic [3:0]  data2_1, data2_2;
    logic [2:0]  state_dbg2;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    localparam logic [335:0] HDR_REQ =
        336'hFFFFFFFFFFFF_AC162DBB53A1_0806_0001_0800_06_04_0001_AC162DBB53A1_C0A8000B_000000000000_C0A80090;
    localparam logic [335:0] HDR_REP =
        336'h001122334455_AC162DBB53A1_0806_0001_0800_06_04_0002_AC162DBB53A1_C0A8000B_001122334455_C0A80090;

    arp_frame_tx dut (
        .clk(clk), .rst(rst), .start(start), .is_reply(is_reply),
        .src_mac(src_mac), .src_ip(src_ip), .tgt_mac(tgt_mac), .tgt_ip(tgt_ip),
        .busy(busy), .done(done), .tx_en(tx_en), .data_1(data_1), .data_2(data_2),
        .state_dbg(state_dbg)
    );

    arp_frame_tx #(.PREAMBLE_BYTES(1), .MIN_FRAME_BYTES(42), .IFG_CYCLES(12)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .is_reply(is_reply),
        .src_mac(src_mac), .src_ip(src_ip), .tgt_mac(tgt_mac), .tgt_ip(tgt_ip),
        .busy(busy2), .done(done2), .tx_en(tx_en2), .data_1(data2_1), .data_2(data2_2),
        .state_dbg(state_dbg2)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // Software CRC-32 reference (reflected 0xEDB88320).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Expected frame: preamble, SFD, header, pad, FCS (LSB first).
    task automatic push_frame(input logic [335:0] hdr, input int pre, input int min_len);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < pre; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 42; i++) begin
            b = hdr[8*(41-i) +: 8];
            exp_q.push_back(b);
            c = crc_byte(c, b);
        end
        for (int i = 42; i < min_len; i++) begin
            exp_q.push_back(8'h00);
            c = crc_byte(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic set_request();
        is_reply = 1'b0;
        src_mac  = 48'hAC162DBB53A1;
        src_ip   = 32'hC0A8000B;
        tgt_mac  = 48'h0A0B0C0D0E0F;
        tgt_ip   = 32'hC0A80090;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Collect bytes of one tx_en burst. waited = idle negedges before it began.
    task automatic grab_frame(input bit use2, output bit ok, output int waited);
        int t, guard;
        got_q.delete();
        ok = 1'b1;
        t  = 0;
        while (!(use2 ? tx_en2 : tx_en) && t < 500) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (!(use2 ? tx_en2 : tx_en)) begin
            ok = 1'b0;
            return;
        end
        guard = 0;
        while ((use2 ? tx_en2 : tx_en) && guard < 2000) begin
            got_q.push_back(use2 ? {data2_2, data2_1} : {data_2, data_1});
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        set_request();
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({busy, done, tx_en, data_2, data_1, state_dbg} !== 14'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got busy=%b done=%b tx_en=%b data=%h state=%0d, required all 0",
                     busy, done, tx_en, {data_2, data_1}, state_dbg);
        end
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({busy, tx_en, busy2, tx_en2} !== 4'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got busy=%b tx_en=%b busy2=%b tx_en2=%b, required 0",
                     busy, tx_en, busy2, tx_en2);
        end
    endtask

    task automatic test_request();
        bit ok; int w, n, bad_ifg; logic [7:0] e; logic [31:0] r;
        set_request();
        push_frame(HDR_REQ, 7, 60);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1 || tx_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL req_accept: got busy=%b tx_en=%b, required busy=1 tx_en=0", busy, tx_en);
        end
        // Inputs changed after acceptance must not leak into the frame.
        src_mac = 48'h123456789ABC; is_reply = 1'b1; tgt_ip = 32'hDEADBEEF;
        grab_frame(1'b0, ok, w);
        vec_cnt++;
        if (!ok || w !== 1) begin
            err_cnt++;
            $display("FAIL req_first_byte: got ok=%b delay=%0d, required ok=1 delay=1", ok, w);
        end
        vec_cnt++;
        if (got_q.size() !== 72) begin
            err_cnt++;
            $display("FAIL req_length: got %0d bytes, required 72", got_q.size());
        end
        n = 0;
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q[i] !== e) begin
                err_cnt++;
                if (n < 4) $display("FAIL req_byte[%0d]: got %h required %h", i, got_q[i], e);
                n++;
            end
        end
        exp_q.delete();
        r = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) r = crc_byte(r, got_q[i]);
        vec_cnt++;
        if (r !== 32'hDEBB20E3) begin
            err_cnt++;
            $display("FAIL req_residue: got %h required debb20e3", r);
        end
        bad_ifg = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (tx_en !== 1'b0 || {data_2, data_1} !== 8'h00) bad_ifg++;
            if (k < 12 && (done !== 1'b0 || busy !== 1'b1)) bad_ifg++;
        end
        vec_cnt++;
        if (bad_ifg !== 0) begin
            err_cnt++;
            $display("FAIL req_ifg: got %0d bad idle cycles, required 0", bad_ifg);
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL req_done: got done=%b busy=%b at idle 12, required done=1 busy=0", done, busy);
        end
        set_request();
    endtask

    task automatic test_reply();
        bit ok; int w, n, t; logic [7:0] e; logic [31:0] r;
        set_request();
        is_reply = 1'b1;
        tgt_mac  = 48'h001122334455;
        push_frame(HDR_REP, 7, 60);
        pulse_start();
        grab_frame(1'b0, ok, w);
        vec_cnt++;
        if (!ok || got_q.size() !== 72) begin
            err_cnt++;
            $display("FAIL rep_length: got ok=%b %0d bytes, required 72", ok, got_q.size());
        end
        vec_cnt++;
        if (got_q.size() >= 30 && {got_q[8], got_q[13], got_q[28], got_q[29]} !== 32'h00550002) begin
            err_cnt++;
            $display("FAIL rep_fields: got dst0=%h dst5=%h oper=%h%h, required 00 55 0002",
                     got_q[8], got_q[13], got_q[28], got_q[29]);
        end
        n = 0;
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q[i] !== e) begin
                err_cnt++;
                if (n < 4) $display("FAIL rep_byte[%0d]: got %h required %h", i, got_q[i], e);
                n++;
            end
        end
        exp_q.delete();
        r = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) r = crc_byte(r, got_q[i]);
        vec_cnt++;
        if (r !== 32'hDEBB20E3) begin
            err_cnt++;
            $display("FAIL rep_residue: got %h required debb20e3", r);
        end
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL rep_busy_drop: got busy=%b after %0d cycles, required 0", busy, t);
        end
        set_request();
    endtask

    task automatic test_ignore();
        int bad_en, bad_ifg, bad_late;
        set_request();
        pulse_start();
        bad_en = 0;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (tx_en !== 1'b1) bad_en++;
            start = (c == 70);
        end
        vec_cnt++;
        if (bad_en !== 0) begin
            err_cnt++;
            $display("FAIL ign_burst: got %0d cycles without tx_en, required 0", bad_en);
        end
        bad_ifg = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tx_en !== 1'b0) bad_ifg++;
            if (k < 12 && done !== 1'b0) bad_ifg++;
            start = (k == 5);
        end
        vec_cnt++;
        if (bad_ifg !== 0) begin
            err_cnt++;
            $display("FAIL ign_ifg: got %0d bad idle cycles, required 0", bad_ifg);
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ign_done: got done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        bad_late = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_en !== 1'b0 || busy !== 1'b0) bad_late++;
        end
        vec_cnt++;
        if (bad_late !== 0) begin
            err_cnt++;
            $display("FAIL ign_extra_frame: got %0d active cycles after done, required 0", bad_late);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int w, c, n, bad; logic [7:0] e; logic [31:0] r;
        set_request();
        pulse_start();
        c = 0;
        while (!tx_en && c < 20) begin
            @(negedge clk);
            c++;
        end
        repeat (30) @(negedge clk);
        vec_cnt++;
        if (tx_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_active: got tx_en=%b at byte 30, required 1", tx_en);
        end
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if ({tx_en, data_2, data_1, busy, done} !== 11'h0) begin
            err_cnt++;
            $display("FAIL mid_async_reset: got tx_en=%b data=%h busy=%b done=%b, required 0",
                     tx_en, {data_2, data_1}, busy, done);
        end
        @(negedge clk) rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (tx_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL mid_no_resume: got %0d active cycles, required 0", bad);
        end
        push_frame(HDR_REQ, 7, 60);
        pulse_start();
        grab_frame(1'b0, ok, w);
        vec_cnt++;
        if (!ok || got_q.size() !== 72) begin
            err_cnt++;
            $display("FAIL mid_length: got ok=%b %0d bytes, required 72", ok, got_q.size());
        end
        n = 0;
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q[i] !== e) begin
                err_cnt++;
                if (n < 4) $display("FAIL mid_byte[%0d]: got %h required %h", i, got_q[i], e);
                n++;
            end
        end
        exp_q.delete();
        r = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) r = crc_byte(r, got_q[i]);
        vec_cnt++;
        if (r !== 32'hDEBB20E3) begin
            err_cnt++;
            $display("FAIL mid_residue: got %h required debb20e3", r);
        end
        repeat (14) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; int w, n, t; logic [7:0] e;
        set_request();
        @(negedge clk) start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(HDR_REQ, 7, 60);
            grab_frame(1'b0, ok, w);
            vec_cnt++;
            if (!ok || got_q.size() !== 72) begin
                err_cnt++;
                $display("FAIL b2b_length[%0d]: got ok=%b %0d bytes, required 72", f, ok, got_q.size());
            end
            if (f > 0) begin
                vec_cnt++;
                if (w !== 13) begin
                    err_cnt++;
                    $display("FAIL b2b_gap[%0d]: got %0d idle cycles, required 13", f, w);
                end
            end
            n = 0;
            for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (got_q[i] !== e) begin
                    err_cnt++;
                    if (n < 4) $display("FAIL b2b_byte[%0d][%0d]: got %h required %h", f, i, got_q[i], e);
                    n++;
                end
            end
            exp_q.delete();
        end
        start = 1'b0;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_stop: got busy=%b tx_en=%b, required 0", busy, tx_en);
        end
    endtask

    task automatic test_small();
        bit ok; int w, n; logic [7:0] e; logic [31:0] r;
        set_request();
        push_frame(HDR_REQ, 1, 42);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        grab_frame(1'b1, ok, w);
        vec_cnt++;
        if (!ok || got_q.size() !== 48) begin
            err_cnt++;
            $display("FAIL small_length: got ok=%b %0d bytes, required 48", ok, got_q.size());
        end
        n = 0;
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (got_q[i] !== e) begin
                err_cnt++;
                if (n < 4) $display("FAIL small_byte[%0d]: got %h required %h", i, got_q[i], e);
                n++;
            end
        end
        exp_q.delete();
        r = 32'hFFFFFFFF;
        for (int i = 2; i < got_q.size(); i++) r = crc_byte(r, got_q[i]);
        vec_cnt++;
        if (r !== 32'hDEBB20E3) begin
            err_cnt++;
            $display("FAIL small_residue: got %h required debb20e3", r);
        end
    endtask

`ifdef ARP_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        bit ok; int w, n, bad; logic [7:0] e;
        set_request();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            push_frame(HDR_REQ, 7, 60);
            grab_frame(1'b0, ok, w);
            vec_cnt++;
            if (!ok || got_q.size() !== 72 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL rpt_frame[%0d]: got ok=%b %0d bytes busy=%b, required 72 busy=1",
                         f, ok, got_q.size(), busy);
            end
            if (f > 0) begin
                vec_cnt++;
                if (w !== 13) begin
                    err_cnt++;
                    $display("FAIL rpt_gap[%0d]: got %0d idle cycles, required 13", f, w);
                end
            end
            n = 0;
            for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (got_q[i] !== e) begin
                    err_cnt++;
                    if (n < 4) $display("FAIL rpt_byte[%0d][%0d]: got %h required %h", f, i, got_q[i], e);
                    n++;
                end
            end
            exp_q.delete();
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL rpt_stop: got %0d active cycles after reset, required 0", bad);
        end
    endtask
`endif

    // Test sequence and final report.
    initial begin
        test_reset();
`ifdef ARP_AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_request();
        test_reply();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
`endif
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
